// File: rtl/julia_frame_sched.sv
// ============================================================================
//  Module      : julia_frame_sched
//  Description : Frame scheduler for the Julia-set pixel engine. Walks every
//                pixel of an H_RES x V_RES frame in raster order, hands the
//                fixed-point coordinate to the engine, captures the RGB565
//                result (or a watchdog colour) and writes it to the frame
//                buffer through a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module julia_frame_sched #(
  parameter int                 H_RES         = 320,
  parameter int                 V_RES         = 240,
  parameter int                 ADDR_W        = 17,
  parameter logic signed [31:0] X_START       = -32'sd1500,
  parameter logic signed [31:0] Y_START       = 32'sd1000,
  parameter logic signed [31:0] STEP_X        = 32'sd10,
  parameter logic signed [31:0] STEP_Y        = 32'sd10,
  parameter logic [15:0]        TIMEOUT       = 16'd4096,
  parameter logic [15:0]        TIMEOUT_COLOR = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [31:0]       cr,
  input  logic signed [31:0]       ci,
  output logic                     calc_enable,
  output logic signed [31:0]       calc_x,
  output logic signed [31:0]       calc_y,
  output logic signed [31:0]       calc_cr,
  output logic signed [31:0]       calc_ci,
  input  logic                     calc_end,
  input  logic [15:0]              calc_color,
  output logic                     pix_we,
  output logic [ADDR_W-1:0]        pix_addr,
  output logic [15:0]              pix_data,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     done
);

  // Counter widths; a one-pixel dimension still gets a 1-bit counter.
  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(V_RES - 1);
  localparam logic [15:0]       WDOG_LAST = TIMEOUT - 16'd1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [15:0]      wdog;

  // Qualified events that drive every register update below.
  logic start_take;
  logic abort_take;
  logic run_active;
  logic wdog_expired;
  logic accept;
  logic last_col;
  logic last_pix;

  assign start_take   = (state == S_IDLE) && start;
  assign abort_take   = (state != S_IDLE) && abort;
  assign run_active   = (state == S_RUN) && !abort_take;
  assign wdog_expired = (wdog == WDOG_LAST);
  assign accept       = (state == S_WRITE) && pix_ready && !abort_take;
  assign last_col     = (col == LAST_COL);
  assign last_pix     = last_col && (row == LAST_ROW);

  // Status and handshake outputs are pure state decodes, so an asynchronous
  // reset clears them in the same instant as the state register.
  assign calc_enable = (state == S_RUN);
  assign pix_we      = (state == S_WRITE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_next = state;
    if (abort_take) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          state_next = S_RUN;
        end
        S_RUN: begin
          if (calc_end || wdog_expired) begin
            state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          if (pix_ready) begin
            state_next = last_pix ? S_DONE : S_LOAD;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Julia constant is captured once per frame so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_cr <= '0;
      calc_ci <= '0;
    end else if (start_take) begin
      calc_cr <= cr;
      calc_ci <= ci;
    end
  end

  // Raster position and fixed-point coordinate advance on each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      calc_x <= '0;
      calc_y <= '0;
    end else if (start_take) begin
      col    <= '0;
      row    <= '0;
      calc_x <= X_START;
      calc_y <= Y_START;
    end else if (accept && !last_pix) begin
      if (!last_col) begin
        col    <= col + COL_W'(1);
        calc_x <= calc_x + STEP_X;
      end else begin
        col    <= '0;
        row    <= row + ROW_W'(1);
        calc_x <= X_START;
        calc_y <= calc_y - STEP_Y;
      end
    end
  end

  // Write address is a running counter that parks at zero whenever idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_addr <= '0;
    end else if (abort_take || start_take || (state == S_DONE)) begin
      pix_addr <= '0;
    end else if (accept && !last_pix) begin
      pix_addr <= pix_addr + ADDR_ONE;
    end
  end

  // Per-pixel watchdog: cleared while loading, counts every RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state == S_LOAD) begin
      wdog <= '0;
    end else if (run_active) begin
      wdog <= wdog + 16'd1;
    end
  end

  // Pixel colour capture; an engine result wins over a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data <= '0;
    end else if (run_active) begin
      if (calc_end) begin
        pix_data <= calc_color;
      end else if (wdog_expired) begin
        pix_data <= TIMEOUT_COLOR;
      end
    end
  end

endmodule

`default_nettype wire
